// File: rtl/md_sched.sv
// md_sched: HI/LO owner and mult/div sequencer beside the E-stage ALU.
// Results are computed at issue and committed after a fixed busy window.
module md_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDop,
    input  logic        E_start,
    input  logic [31:0] E_srcA,
    input  logic [31:0] E_srcB,
    input  logic        D_isMD,
    output logic        busy,
    output logic        MD_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        sIdle,
        sBusy
    } mdState_t;

    localparam logic [3:0] multCyc = 4'(MULT_CYC);
    localparam logic [3:0] divCyc  = 4'(DIV_CYC);

    mdState_t    state;
    logic [3:0]  cnt;
    logic [31:0] pHI;
    logic [31:0] pLO;
    logic        pKeep;

    logic        isLong;
    logic        isMul;
    logic        divZero;
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] safeB;
    logic [31:0] safeMagB;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] resHi;
    logic [31:0] resLo;

    assign isLong = E_start && (E_MDop >= 3'd1) && (E_MDop <= 3'd4);
    assign isMul  = (E_MDop == 3'd1) || (E_MDop == 3'd2);
    assign divZero = (E_srcB == 32'd0) && !isMul;

    assign busy     = (state == sBusy);
    assign MD_stall = D_isMD && (busy || isLong);

    // Signed divide runs on magnitudes so INT_MIN / -1 falls out naturally.
    always_comb begin
        prodS    = {{32{E_srcA[31]}}, E_srcA} * {{32{E_srcB[31]}}, E_srcB};
        prodU    = {32'd0, E_srcA} * {32'd0, E_srcB};
        magA     = E_srcA[31] ? -E_srcA : E_srcA;
        magB     = E_srcB[31] ? -E_srcB : E_srcB;
        safeB    = (E_srcB == 32'd0) ? 32'd1 : E_srcB;
        safeMagB = (magB == 32'd0) ? 32'd1 : magB;
        uq       = magA / safeMagB;
        ur       = magA % safeMagB;
        resHi    = 32'd0;
        resLo    = 32'd0;
        unique case (E_MDop)
            3'd1: begin
                resHi = prodS[63:32];
                resLo = prodS[31:0];
            end
            3'd2: begin
                resHi = prodU[63:32];
                resLo = prodU[31:0];
            end
            3'd3: begin
                resLo = (E_srcA[31] ^ E_srcB[31]) ? -uq : uq;
                resHi = E_srcA[31] ? -ur : ur;
            end
            3'd4: begin
                resLo = E_srcA / safeB;
                resHi = E_srcA % safeB;
            end
            default: begin
                resHi = 32'd0;
                resLo = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= sIdle;
            cnt   <= 4'd0;
            pHI   <= 32'd0;
            pLO   <= 32'd0;
            pKeep <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            unique case (state)
                sIdle: begin
                    if (isLong) begin
                        pHI   <= resHi;
                        pLO   <= resLo;
                        pKeep <= divZero;
                        cnt   <= isMul ? multCyc : divCyc;
                        state <= sBusy;
                    end else if (E_start && E_MDop == 3'd5) begin
                        HI <= E_srcA;
                    end else if (E_start && E_MDop == 3'd6) begin
                        LO <= E_srcA;
                    end
                end
                sBusy: begin
                    if (cnt == 4'd1) begin
                        if (!pKeep) begin
                            HI <= pHI;
                            LO <= pLO;
                        end
                        cnt   <= 4'd0;
                        state <= sIdle;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= sIdle;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: long-op results queued at issue,
// monitor checks HI/LO and busy length whenever busy falls.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  E_MDop = 3'd0;
    logic        E_start = 1'b0;
    logic [31:0] E_srcA = 32'd0;
    logic [31:0] E_srcB = 32'd0;
    logic        D_isMD = 1'b0;
    logic        busy;
    logic        MD_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    md_sched dut (
        .clk(clk), .reset(reset), .E_MDop(E_MDop), .E_start(E_start),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .D_isMD(D_isMD),
        .busy(busy), .MD_stall(MD_stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    bit          expectAbort = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] refOp(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {mHi, mLo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {mHi, mLo};
                return {a % b, a / b};
            end
            default: return {mHi, mLo};
        endcase
    endfunction

    // Monitor: a busy->idle transition is the DUT presenting a result.
    initial begin
        bit   prevBusy = 0;
        int   bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) bcnt++;
            if (prevBusy && !busy) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got busy fall expected none");
                end else begin
                    e = sbq.pop_front();
                    if (expectAbort) begin
                        expectAbort = 0;
                    end else begin
                        check("done_hi", HI, e.hi);
                        check("done_lo", LO, e.lo);
                        check("busy_len", 32'(bcnt), 32'(e.cyc));
                    end
                end
                bcnt = 0;
            end
            prevBusy = busy;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd);
        bit          isLong;
        logic [63:0] r;
        exp_t        e;
        isLong = (op >= 3'd1 && op <= 3'd4);
        @(negedge clk);
        E_MDop = op;
        E_srcA = a;
        E_srcB = b;
        E_start = 1'b1;
        D_isMD = dmd;
        #1 check("stall_issue", 32'(MD_stall), 32'(dmd & isLong));
        if (isLong) begin
            r = refOp(op, a, b);
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.cyc = (op <= 3'd2) ? 5 : 10;
            sbq.push_back(e);
            mHi = r[63:32];
            mLo = r[31:0];
        end else if (op == 3'd5) begin
            mHi = a;
        end else if (op == 3'd6) begin
            mLo = a;
        end
        @(posedge clk);
        #1;
        E_start = 1'b0;
        E_MDop = 3'd0;
        if (!isLong) begin
            check("short_hi", HI, mHi);
            check("short_lo", LO, mLo);
            check("short_busy", 32'(busy), 32'd0);
        end
    endtask

    // Op presented while BUSY must be dropped.
    task automatic inject(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hiNow);
        @(negedge clk);
        E_MDop = op;
        E_srcA = a;
        E_srcB = b;
        E_start = 1'b1;
        D_isMD = 1'b1;
        #1 check("stall_inject", 32'(MD_stall), 32'd1);
        @(posedge clk);
        #1;
        E_start = 1'b0;
        E_MDop = 3'd0;
        D_isMD = 1'b0;
        check("inject_hi", HI, hiNow);
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    initial begin
        logic [31:0] oldHi, oldLo, a, b;
        logic [2:0]  op;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(MD_stall), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b1;

        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        waitIdle();

        oldHi = mHi;
        oldLo = mLo;
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("multu_t4_hi", HI, oldHi);
        check("multu_t4_lo", LO, oldLo);
        check("multu_t4_busy", 32'(busy), 32'd1);
        waitIdle();
        check("multu_hi", HI, 32'h00000001);

        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        waitIdle();
        check("div_neg_lo", LO, 32'hFFFFFFFD);
        issue(3'd4, 32'd7, 32'd0, 1'b0);
        waitIdle();
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        waitIdle();
        check("div_ovf_lo", LO, 32'h80000000);

        issue(3'd3, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check("stall_busy", 32'(MD_stall), 32'd1);
        end
        @(negedge clk);
        #1;
        check("stall_drop", 32'(MD_stall), 32'd0);
        check("mfhi_new", HI, 32'd2);
        D_isMD = 1'b0;

        issue(3'd5, 32'h12345678, 32'd0, 1'b0);
        oldHi = mHi;
        issue(3'd1, 32'd3, 32'd4, 1'b0);
        inject(3'd5, 32'hDEADBEEF, 32'd0, oldHi);
        inject(3'd3, 32'd9, 32'd0, oldHi);
        waitIdle();

        issue(3'd1, 32'h7, 32'h9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expectAbort = 1;
        @(posedge clk);
        #1;
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        mHi = 32'd0;
        mLo = 32'd0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 6));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            issue(op, a, b, 1'($urandom_range(0, 1)));
            D_isMD = 1'b0;
            if (op >= 3'd1 && op <= 3'd4 && $urandom_range(0, 3) == 0)
                inject(3'($urandom_range(1, 6)), $urandom, $urandom, HI);
            waitIdle();
        end

        for (int n = 0; n < 40 && sbq.size() != 0; n++) @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
